// File: rtl/row_router_array.sv
// row_router_array: multi-lane address-matched beat router with skew padding,
// reader backpressure and aligned all-lane pop with registered output.
module row_router_array #(
  parameter int NUM_ROWS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_clear,
  input  logic                           i_start,
  input  logic                           i_skew_en,
  input  logic [NUM_ROWS-1:0]            i_addr_wr_en,
  input  logic [NUM_ROWS*ADDR_WIDTH-1:0] i_addr_wr_data,
  output logic [NUM_ROWS-1:0]            o_addr_full,
  input  logic                           i_rd_valid,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  input  logic [DATA_WIDTH-1:0]          i_rd_data,
  output logic                           o_rd_stall,
  input  logic                           i_pop_en,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] o_data_out,
  output logic                           o_data_valid,
  output logic [NUM_ROWS-1:0]            o_lane_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(NUM_ROWS) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HOT_C  = CW'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, PAD, ROUTE} state_t;
  logic [NUM_ROWS-1:0]                 d_empty, d_hot;
  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0] d_head;
  logic [NUM_ROWS*DATA_WIDTH-1:0]      data_q;
  logic                                valid_q, pop_acc;
  assign pop_acc      = i_pop_en & ~|d_empty;
  assign o_rd_stall   = |d_hot;
  assign o_data_out   = data_q;
  assign o_data_valid = valid_q;
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_lane
    state_t                state_q, state_d;
    logic [KW-1:0]         pad_q, pad_d;
    logic [ADDR_WIDTH-1:0] am_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dm_q [FIFO_DEPTH];
    logic [PW-1:0]         a_rd_q, a_wr_q, d_rd_q, d_wr_q;
    logic [CW-1:0]         a_cnt_q, d_cnt_q;
    logic                  a_push, hit, pad_wr, d_push;
    logic [DATA_WIDTH-1:0] d_wdata;
    assign a_push  = i_addr_wr_en[g] & (a_cnt_q != FULL_C) & ~i_clear;
    assign hit     = (state_q == ROUTE) & i_rd_valid & ~o_rd_stall & (a_cnt_q != '0)
                   & (am_q[a_rd_q] == i_rd_addr) & (d_cnt_q != FULL_C);
    assign pad_wr  = (state_q == PAD) & (d_cnt_q != FULL_C);
    assign d_push  = hit | pad_wr;
    assign d_wdata = hit ? i_rd_data : '0;
    assign o_addr_full[g] = a_cnt_q == FULL_C;
    assign o_lane_done[g] = (state_q == ROUTE) & (a_cnt_q == '0);
    assign d_empty[g]     = d_cnt_q == '0;
    assign d_hot[g]       = d_cnt_q >= HOT_C;
    assign d_head[g]      = dm_q[d_rd_q];
    // Lanes above 0 insert r zero words before routing so columns arrive skewed.
    always_comb begin
      state_d = state_q;
      pad_d   = pad_q;
      if (state_q == IDLE && i_start) begin
        state_d = (i_skew_en && g > 0) ? PAD : ROUTE;
        pad_d   = (i_skew_en && g > 0) ? KW'(g) : '0;
      end else if (pad_wr) begin
        state_d = (pad_q == KW'(1)) ? ROUTE : PAD;
        pad_d   = pad_q - KW'(1);
      end
    end
    always_ff @(posedge i_clk) begin
      if (a_push) am_q[a_wr_q] <= i_addr_wr_data[g*ADDR_WIDTH +: ADDR_WIDTH];
      if (d_push) dm_q[d_wr_q] <= d_wdata;
    end
    always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
        state_q <= IDLE;
        pad_q   <= '0;
        a_rd_q  <= '0;
        a_wr_q  <= '0;
        a_cnt_q <= '0;
        d_rd_q  <= '0;
        d_wr_q  <= '0;
        d_cnt_q <= '0;
      end else begin
        state_q <= state_d;
        pad_q   <= pad_d;
        a_wr_q  <= a_wr_q + PW'(a_push);
        a_rd_q  <= a_rd_q + PW'(hit);
        a_cnt_q <= a_cnt_q + CW'(a_push) - CW'(hit);
        d_wr_q  <= d_wr_q + PW'(d_push);
        d_rd_q  <= d_rd_q + PW'(pop_acc);
        d_cnt_q <= d_cnt_q + CW'(d_push) - CW'(pop_acc);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop_acc;
      if (pop_acc) data_q <= d_head;
    end
  end
endmodule
